pdm_cic_decimator: RTL and testbench
====================================

Name: pdm_cic_decimator

Overview:
- Multi-channel PDM front end. It generates the microphone PDM clock and samples NUM_MICS PDM lines.
- Each channel runs a 3rd-order CIC decimator, producing signed PCM words at pdm rate / 2^DEC_LOG2.
- Each decimated frame goes out as a channel-sequential valid/ready stream.
- It replaces the plain per-mic accumulators and feeds the per-mic FIFO write side directly.

Parameters:
- NUM_MICS, 25, number of PDM input lines/channels.
- CLK_DIV, 12, clk cycles per pdm_clk half-period (pdm_clk period = 2*CLK_DIV clk).
- DEC_LOG2, 6, log2 of decimation ratio R (R=64).
- OUT_WIDTH, 16, output PCM word width (signed).

Ports:
- clk  in  1  system clock; the only clock in the block.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  run enable; low = divider held, pdm_clk low, all filter state cleared.
- pdm  in  NUM_MICS  PDM data from the mics.
- pdm_clk  out  1  generated microphone clock (register output).
- out_valid  out  1  PCM word available.
- out_ready  in  1  downstream accepts the word when out_valid & out_ready.
- out_data  out  OUT_WIDTH  signed PCM sample.
- out_chan  out  5  channel index of out_data (0..NUM_MICS-1).
- out_first  out  1  high with channel 0 of each frame.
- overrun  out  1  one-cycle pulse when a frame is dropped.

Behaviour:
- Reset (async, rst=1) or en=0:
  - pdm_clk=0; divider, decimation counter, warm-up counter, integrators, comb delays all 0.
  - out_valid=0, out_data=0, out_chan=0, out_first=0, overrun=0.
  - rst takes effect immediately. A frame in progress is abandoned, not completed.
- Clock divider:
  - Counter 0..CLK_DIV-1; at CLK_DIV-1 it wraps and pdm_clk toggles.
  - The sample strobe fires in the cycle where pdm_clk goes 0->1, and pdm is sampled in that cycle.
- Input mapping: pdm bit 1 -> +1, 0 -> -1.
- Internal width W = 3*DEC_LOG2+2 (20), two's complement.
- Integrators (3 cascaded per channel):
  - Update only on the sample strobe.
  - Arithmetic is modulo 2^W; wrap-around is intended and must not saturate.
- Decimation counter:
  - Counts strobes 0..2^DEC_LOG2-1.
  - On the strobe where it is 2^DEC_LOG2-1, a decimation tick registers for the next cycle.
- Comb stage:
  - On the tick cycle, 3 cascaded combs (differential delay 1) evaluate all channels in parallel from the last integrator value.
  - Results latch into a frame register, 1 clk after the final integrator update.
- Scaling: y = comb_out >>> (3*DEC_LOG2+1-OUT_WIDTH), i.e. shift 3.
  - Saturate to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1].
  - Full-scale +2^18 gives 32767; -2^18 gives -32768.
- Warm-up:
  - The first 3 ticks after reset/en rise are not emitted.
  - A 2-bit counter saturates at 3.
- Serializer, states IDLE and SEND:
  - On a latched frame: SEND, out_chan=0, out_first=1, out_valid=1 in the cycle after the latch.
  - out_data/out_chan hold stable while out_valid & ~out_ready.
  - Each accept increments out_chan. The accept with out_chan=NUM_MICS-1 returns to IDLE with out_valid=0 the next cycle.
  - out_first is high only for chan 0.
- Overrun:
  - A tick that arrives while in SEND drops the new frame; the current frame is not overwritten.
  - overrun pulses 1 cycle and the comb state still advances.
  - Tick and final accept in the same cycle: the final accept completes and the new frame is taken (no overrun).
- Nominal frame period = 2^DEC_LOG2*2*CLK_DIV = 1536 clk; a frame needs ≥ NUM_MICS cycles with out_ready=1.

Decomposition:
- Shared package: CIC_ORDER=3, W function of DEC_LOG2, output shift, saturation limits, serializer state enum.
- One sub-module: cic3_channel (3 integrators + 3 combs + scale/saturate for one channel), generated NUM_MICS times.
- Divider, counters and serializer stay in the top.

Test Plan:
- All pdm=1, out_ready=1:
  - First emitted frame is the 4th tick, ~4*1536 clk after reset release.
  - Every channel = 32767; out_chan sequence 0..24, out_first only on 0.
- All pdm=0: every channel -32768 from the 4th tick onward.
- Alternating 1,0 per sample on all lines: every emitted word = 0 exactly.
- Only pdm[7]=1, others 0: chan 7 = 32767, all others -32768; pdm_clk period measured = 24 clk.
- Backpressure:
  - Hold out_ready=0 for 2000 clk mid-frame: out_data/out_chan stable throughout.
  - One overrun pulse at the next tick; no lost or duplicated channels once ready resumes.
- Reset mid-frame at out_chan=10: out_valid and pdm_clk go 0 asynchronously. After release, no output for 3 ticks, then a full frame starting at chan 0.

Source files
------------

// File: rtl/pdm_cic_decimator_pkg.sv
// Shared constants and helpers for the PDM CIC decimator: filter order,
// internal width, output shift, saturation limits and serializer states.
package pdm_cic_decimator_pkg;

  localparam int CIC_ORDER = 3;

  function automatic int cic_width(input int dec_log2);
    return CIC_ORDER * dec_log2 + 2;
  endfunction

  function automatic int cic_shift(input int dec_log2, input int out_w);
    return CIC_ORDER * dec_log2 + 1 - out_w;
  endfunction

  function automatic int sat_hi(input int out_w);
    return 2 ** (out_w - 1) - 1;
  endfunction

  function automatic int sat_lo(input int out_w);
    return -(2 ** (out_w - 1));
  endfunction

  typedef enum logic {
    SER_IDLE,
    SER_SEND
  } ser_state_t;

endpackage

// File: rtl/pdm_cic_decimator_cic3_channel.sv
// One PDM channel: three modulo-2^W integrators at the PDM rate, three combs
// at the decimated rate, then shift and saturate into the frame register.
module cic3_channel
  import pdm_cic_decimator_pkg::*;
#(
  parameter int DEC_LOG2  = 6,
  parameter int OUT_WIDTH = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        en,
  input  logic                        strobe,
  input  logic                        pdm_bit,
  input  logic                        tick,
  input  logic                        load,
  output logic signed [OUT_WIDTH-1:0] sample
);

  localparam int W     = cic_width(DEC_LOG2);
  localparam int SHIFT = cic_shift(DEC_LOG2, OUT_WIDTH);
  localparam logic signed [W-1:0] SAT_HI = W'(sat_hi(OUT_WIDTH));
  localparam logic signed [W-1:0] SAT_LO = W'(sat_lo(OUT_WIDTH));

  logic signed [W-1:0] x_p0;
  logic signed [W-1:0] int1_p0, int2_p0, int3_p0;
  logic signed [W-1:0] dly1_p1, dly2_p1, dly3_p1;
  logic signed [W-1:0] comb1_p1, comb2_p1, comb3_p1;

  function automatic logic signed [OUT_WIDTH-1:0] scale_sat(input logic signed [W-1:0] v);
    logic signed [W-1:0] s;
    s = v >>> SHIFT;
    if (s > SAT_HI)      return SAT_HI[OUT_WIDTH-1:0];
    else if (s < SAT_LO) return SAT_LO[OUT_WIDTH-1:0];
    else                 return s[OUT_WIDTH-1:0];
  endfunction

  assign x_p0 = pdm_bit ? {{(W-1){1'b0}}, 1'b1} : {W{1'b1}};

  // p1: comb cascade evaluated in the tick cycle from the latest integrator value
  assign comb1_p1 = int3_p0 - dly1_p1;
  assign comb2_p1 = comb1_p1 - dly2_p1;
  assign comb3_p1 = comb2_p1 - dly3_p1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      int1_p0 <= '0;
      int2_p0 <= '0;
      int3_p0 <= '0;
      dly1_p1 <= '0;
      dly2_p1 <= '0;
      dly3_p1 <= '0;
      sample  <= '0;
    end else if (!en) begin
      int1_p0 <= '0;
      int2_p0 <= '0;
      int3_p0 <= '0;
      dly1_p1 <= '0;
      dly2_p1 <= '0;
      dly3_p1 <= '0;
      sample  <= '0;
    end else begin
      if (strobe) begin
        int1_p0 <= int1_p0 + x_p0;
        int2_p0 <= int2_p0 + int1_p0;
        int3_p0 <= int3_p0 + int2_p0;
      end
      if (tick) begin
        dly1_p1 <= int3_p0;
        dly2_p1 <= comb1_p1;
        dly3_p1 <= comb2_p1;
      end
      if (load) sample <= scale_sat(comb3_p1);
    end
  end

endmodule

// File: rtl/pdm_cic_decimator.sv
// Multi-mic PDM front end: pdm_clk generation, per-channel CIC3 decimation,
// and a channel-sequential valid/ready serializer with overrun detection.
module pdm_cic_decimator
  import pdm_cic_decimator_pkg::*;
#(
  parameter int NUM_MICS  = 25,
  parameter int CLK_DIV   = 12,
  parameter int DEC_LOG2  = 6,
  parameter int OUT_WIDTH = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        en,
  input  logic [NUM_MICS-1:0]         pdm,
  output logic                        pdm_clk,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic signed [OUT_WIDTH-1:0] out_data,
  output logic [4:0]                  out_chan,
  output logic                        out_first,
  output logic                        overrun
);

  localparam int DIV_W = $clog2(CLK_DIV + 1);

  logic [DIV_W-1:0]    div_cnt;
  logic [DEC_LOG2-1:0] dec_cnt;
  logic [1:0]          warm_cnt;
  logic                div_wrap, strobe_p0, tick_p1, load_p1, warm_done;
  logic                accept, final_accept, overrun_nxt;
  ser_state_t          state, state_nxt;
  logic [4:0]          chan, chan_nxt;
  logic signed [OUT_WIDTH-1:0] sample [NUM_MICS];

  // p0: sample strobe coincides with the pdm_clk 0->1 edge
  assign div_wrap  = (div_cnt == DIV_W'(CLK_DIV - 1));
  assign strobe_p0 = en & div_wrap & ~pdm_clk;
  assign warm_done = (warm_cnt == 2'd3);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt  <= '0;
      pdm_clk  <= 1'b0;
      dec_cnt  <= '0;
      warm_cnt <= '0;
      tick_p1  <= 1'b0;
    end else if (!en) begin
      div_cnt  <= '0;
      pdm_clk  <= 1'b0;
      dec_cnt  <= '0;
      warm_cnt <= '0;
      tick_p1  <= 1'b0;
    end else begin
      div_cnt <= div_wrap ? '0 : div_cnt + 1'b1;
      if (div_wrap) pdm_clk <= ~pdm_clk;
      if (strobe_p0) dec_cnt <= dec_cnt + 1'b1;
      tick_p1 <= strobe_p0 & (&dec_cnt);
      if (tick_p1 && !warm_done) warm_cnt <= warm_cnt + 1'b1;
    end
  end

  for (genvar m = 0; m < NUM_MICS; m++) begin : g_ch
    cic3_channel #(
      .DEC_LOG2 (DEC_LOG2),
      .OUT_WIDTH(OUT_WIDTH)
    ) u_ch (
      .clk    (clk),
      .rst    (rst),
      .en     (en),
      .strobe (strobe_p0),
      .pdm_bit(pdm[m]),
      .tick   (tick_p1),
      .load   (load_p1),
      .sample (sample[m])
    );
  end

  // p2: serializer walks the latched frame one channel per accept
  assign out_valid    = (state == SER_SEND);
  assign accept       = out_valid & out_ready;
  assign final_accept = accept & (chan == 5'(NUM_MICS - 1));
  assign out_chan     = chan;
  assign out_first    = out_valid & (chan == 5'd0);

  always_comb begin
    state_nxt   = state;
    chan_nxt    = chan;
    overrun_nxt = 1'b0;
    load_p1     = 1'b0;
    if (accept) begin
      if (final_accept) begin
        state_nxt = SER_IDLE;
        chan_nxt  = 5'd0;
      end else begin
        chan_nxt = chan + 1'b1;
      end
    end
    // A final accept in the tick cycle frees the frame register in time
    if (tick_p1 && warm_done) begin
      if (state == SER_IDLE || final_accept) begin
        load_p1   = 1'b1;
        state_nxt = SER_SEND;
        chan_nxt  = 5'd0;
      end else begin
        overrun_nxt = 1'b1;
      end
    end
  end

  always_comb begin
    out_data = '0;
    if (out_valid) out_data = sample[chan];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= SER_IDLE;
      chan    <= '0;
      overrun <= 1'b0;
    end else if (!en) begin
      state   <= SER_IDLE;
      chan    <= '0;
      overrun <= 1'b0;
    end else begin
      state   <= state_nxt;
      chan    <= chan_nxt;
      overrun <= overrun_nxt;
    end
  end

endmodule

// File: tb/tb_pdm_cic_decimator.sv
// Directed bench for pdm_cic_decimator: DC full-scale inputs, alternating
// input, single hot mic, backpressure with overrun, and reset mid-frame.
module tb_pdm_cic_decimator;

  localparam int NUM_MICS  = 25;
  localparam int CLK_DIV   = 12;
  localparam int DEC_LOG2  = 6;
  localparam int OUT_WIDTH = 16;
  localparam int LAT_LO    = 4 * 1536 - 40;
  localparam int LAT_HI    = 4 * 1536 + 40;
  localparam logic signed [15:0] POS_FS = 16'sd32767;
  localparam logic signed [15:0] NEG_FS = -16'sd32768;

  logic                        clk = 1'b0;
  logic                        rst = 1'b1;
  logic                        en = 1'b0;
  logic [NUM_MICS-1:0]         pdm = '0;
  logic                        out_ready = 1'b0;
  logic                        pdm_clk, out_valid, out_first, overrun;
  logic signed [OUT_WIDTH-1:0] out_data;
  logic [4:0]                  out_chan;

  int checks = 0;
  int failures = 0;
  int ovr_cnt = 0;
  logic alt_mode = 1'b0;
  logic signed [15:0] exp_frame [NUM_MICS];

  pdm_cic_decimator #(
    .NUM_MICS (NUM_MICS),
    .CLK_DIV  (CLK_DIV),
    .DEC_LOG2 (DEC_LOG2),
    .OUT_WIDTH(OUT_WIDTH)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .pdm      (pdm),
    .pdm_clk  (pdm_clk),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_chan (out_chan),
    .out_first(out_first),
    .overrun  (overrun)
  );

  always #5 clk = ~clk;

  // Alternating pattern changes on pdm_clk falling, far from the sampling edge
  always @(negedge pdm_clk) if (alt_mode) pdm = ~pdm;

  always @(negedge clk) if (overrun === 1'b1) ovr_cnt++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic set_exp(input logic signed [15:0] base, input int hot, input logic signed [15:0] hot_v);
    for (int m = 0; m < NUM_MICS; m++) exp_frame[m] = (m == hot) ? hot_v : base;
  endtask

  task automatic wait_valid(input int limit, output int cyc);
    cyc = 0;
    while (out_valid !== 1'b1 && cyc < limit) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  // Checks words first_ch..last_ch with out_ready held high
  task automatic recv_words(input string tag, input int first_ch, input int last_ch);
    for (int i = first_ch; i <= last_ch; i++) begin
      check(tag, {9'd0, out_valid, out_first, out_chan, out_data},
            {9'd0, 1'b1, (i == 0), 5'(i), exp_frame[i]});
      @(negedge clk);
    end
  endtask

  initial begin
    int cyc;
    int t_rise;
    int ovr0;
    logic stable;
    logic prev_pclk;

    // Reset state
    en = 1'b1;
    out_ready = 1'b1;
    pdm = '1;
    repeat (3) @(negedge clk);
    check("rst_pdm_clk", 32'(pdm_clk), 32'd0);
    check("rst_outputs", {27'd0, out_valid, out_first, overrun, out_chan == 5'd0, out_data == 16'sd0},
          {27'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1});

    // All ones: first frame after the 4th tick, full-scale positive
    rst = 1'b0;
    set_exp(POS_FS, -1, POS_FS);
    wait_valid(7000, cyc);
    check("ones_latency_in_window", 32'(cyc >= LAT_LO && cyc <= LAT_HI), 32'd1);
    recv_words("ones_word", 0, NUM_MICS - 1);
    check("ones_valid_drops", 32'(out_valid), 32'd0);

    // en low clears, then all zeros
    en = 1'b0;
    pdm = '0;
    @(negedge clk);
    check("en_low_pdm_clk", 32'(pdm_clk), 32'd0);
    check("en_low_valid", 32'(out_valid), 32'd0);
    en = 1'b1;
    set_exp(NEG_FS, -1, NEG_FS);
    wait_valid(7000, cyc);
    check("zeros_latency_in_window", 32'(cyc >= LAT_LO && cyc <= LAT_HI), 32'd1);
    recv_words("zeros_word", 0, NUM_MICS - 1);

    // Alternating 1,0 per sample gives exactly zero
    en = 1'b0;
    @(negedge clk);
    pdm = '0;
    alt_mode = 1'b1;
    en = 1'b1;
    set_exp(16'sd0, -1, 16'sd0);
    wait_valid(7000, cyc);
    check("alt_latency_in_window", 32'(cyc >= LAT_LO && cyc <= LAT_HI), 32'd1);
    recv_words("alt_word", 0, NUM_MICS - 1);
    alt_mode = 1'b0;

    // Single hot mic 7, plus pdm_clk period measurement
    en = 1'b0;
    @(negedge clk);
    pdm = '0;
    pdm[7] = 1'b1;
    en = 1'b1;
    cyc = 0;
    t_rise = -1;
    prev_pclk = 1'b0;
    while (cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (pdm_clk === 1'b1 && prev_pclk === 1'b0) begin
        if (t_rise >= 0) break;
        t_rise = cyc;
      end
      prev_pclk = pdm_clk;
    end
    check("pdm_clk_period", 32'(cyc - t_rise), 32'd24);
    set_exp(NEG_FS, 7, POS_FS);
    wait_valid(7000, cyc);
    check("hot7_valid", 32'(out_valid), 32'd1);
    recv_words("hot7_word", 0, NUM_MICS - 1);

    // Backpressure mid-frame: hold at chan 5 for 2000 clk across one tick
    wait_valid(2000, cyc);
    recv_words("bp_pre_word", 0, 4);
    out_ready = 1'b0;
    ovr0 = ovr_cnt;
    stable = 1'b1;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (!(out_valid === 1'b1 && out_chan === 5'd5 && out_data === exp_frame[5] && out_first === 1'b0))
        stable = 1'b0;
    end
    check("bp_hold_stable", 32'(stable), 32'd1);
    check("bp_overrun_pulses", 32'(ovr_cnt - ovr0), 32'd1);
    out_ready = 1'b1;
    recv_words("bp_resume_word", 5, NUM_MICS - 1);
    check("bp_frame_done", 32'(out_valid), 32'd0);
    wait_valid(2000, cyc);
    recv_words("bp_next_word", 0, NUM_MICS - 1);
    check("bp_no_extra_overrun", 32'(ovr_cnt - ovr0), 32'd1);

    // Asynchronous reset in the middle of a frame, with pdm_clk high
    wait_valid(2000, cyc);
    recv_words("rst_pre_word", 0, 9);
    out_ready = 1'b0;
    check("rst_pre_chan", 32'(out_chan), 32'd10);
    cyc = 0;
    while (pdm_clk !== 1'b1 && cyc < 30) begin
      @(negedge clk);
      cyc++;
    end
    check("rst_pre_pdm_clk_high", 32'(pdm_clk), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("rst_async_valid", 32'(out_valid), 32'd0);
    check("rst_async_pdm_clk", 32'(pdm_clk), 32'd0);
    check("rst_async_chan_data", {11'd0, out_chan, out_data}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    out_ready = 1'b1;
    rst = 1'b0;
    wait_valid(7000, cyc);
    check("rst_post_latency_in_window", 32'(cyc >= LAT_LO && cyc <= LAT_HI), 32'd1);
    recv_words("rst_post_word", 0, NUM_MICS - 1);
    check("rst_post_frame_done", 32'(out_valid), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
